// File: rtl/openhw_fpu_pkg.sv
// Shared FPU post-processing definitions: op codes, rounding-mode constants
// and the quotient-sign helper used by the rounding-sign resolver.
package openhw_fpu_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_FMA  = 2'b01,
    OP_DIV  = 2'b10,
    OP_CVT  = 2'b11
  } op_e;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RDN = 3'b010;

  // Sqrt results take only the radicand sign; divides take the xor of both.
  function automatic logic quot_sign(input logic xs, input logic ys, input logic sqrt);
    return xs ^ (ys & ~sqrt);
  endfunction

endpackage

// File: rtl/openhw_roundsign_lane.sv
// Combinational single-lane pre-rounding sign selector.
module openhw_roundsign_lane
  import openhw_fpu_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [2:0] i_frm,
  input  logic       i_xs,
  input  logic       i_ys,
  input  logic       i_cvt_cs,
  input  logic       i_fma_ss,
  input  logic       i_sqrt,
  input  logic       i_fma_zero,
  output logic       o_ms_c
);

  // Exact-zero FMA cancellation yields -0 only when rounding toward -inf.
  always_comb begin
    o_ms_c = 1'b0;
    case (op_e'(i_op))
      OP_FMA:  o_ms_c = i_fma_zero ? (i_frm == RDN) : i_fma_ss;
      OP_DIV:  o_ms_c = quot_sign(i_xs, i_ys, i_sqrt);
      OP_CVT:  o_ms_c = i_cvt_cs;
      default: o_ms_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/openhw_roundsign_pipe.sv
// Multi-lane rounding-sign resolver followed by a STAGES-deep elastic
// valid/ready pipeline with synchronous flush.
module openhw_roundsign_pipe
  import openhw_fpu_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAGW   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               Flush,
  input  logic               InValid,
  output logic               InReady,
  input  logic [TAGW-1:0]    InTag,
  input  logic [2:0]         Frm,
  input  logic [LANES-1:0]   Xs,
  input  logic [LANES-1:0]   Ys,
  input  logic [LANES-1:0]   CvtCs,
  input  logic [LANES-1:0]   FmaSs,
  input  logic [LANES-1:0]   Sqrt,
  input  logic [LANES-1:0]   FmaZero,
  input  logic [2*LANES-1:0] OpSel,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [TAGW-1:0]    OutTag,
  output logic [LANES-1:0]   Ms
);

  logic [LANES-1:0]  w_ms;
  logic [STAGES-1:0] w_load;
  logic              w_in_acc;

  logic [STAGES-1:0] r_vld;
  logic [TAGW-1:0]   r_tag [STAGES];
  logic [LANES-1:0]  r_ms  [STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    openhw_roundsign_lane u_lane (
      .i_op       (OpSel[2*i +: 2]),
      .i_frm      (Frm),
      .i_xs       (Xs[i]),
      .i_ys       (Ys[i]),
      .i_cvt_cs   (CvtCs[i]),
      .i_fma_ss   (FmaSs[i]),
      .i_sqrt     (Sqrt[i]),
      .i_fma_zero (FmaZero[i]),
      .o_ms_c     (w_ms[i])
    );
  end

  // Slot k may load if downstream is ready or any slot at or after k is empty.
  always_comb begin
    logic acc;
    w_load = '0;
    acc    = OutReady;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc       = acc | ~r_vld[k];
      w_load[k] = acc;
    end
  end

  assign InReady  = ~Flush & w_load[0];
  assign w_in_acc = InValid & InReady;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_tag[k] <= '0;
        r_ms[k]  <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= w_in_acc;
        r_tag[0] <= InTag;
        r_ms[0]  <= w_ms;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= r_vld[k-1];
          r_tag[k] <= r_tag[k-1];
          r_ms[k]  <= r_ms[k-1];
        end
      end
      // Flush wins over any advance; stale data is harmless once invalid.
      if (Flush) r_vld <= '0;
    end
  end

  assign OutValid = r_vld[STAGES-1];
  assign OutTag   = r_tag[STAGES-1];
  assign Ms       = r_ms[STAGES-1];

endmodule

// File: tb/tb_openhw_roundsign_pipe.sv
// Scoreboard bench for openhw_roundsign_pipe (LANES=2, STAGES=2, TAGW=4).
module tb_openhw_roundsign_pipe;

  localparam int unsigned LANES  = 2;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAGW   = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [TAGW-1:0]  InTag;
  logic [2:0]       Frm;
  logic [1:0]       Xs, Ys, CvtCs, FmaSs, Sqrt, FmaZero;
  logic [3:0]       OpSel;
  logic             OutValid;
  logic             OutReady;
  logic [TAGW-1:0]  OutTag;
  logic [1:0]       Ms;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] sb_q[$];

  always #5 clk = ~clk;

  openhw_roundsign_pipe #(.LANES(LANES), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .InTag(InTag), .Frm(Frm), .Xs(Xs), .Ys(Ys), .CvtCs(CvtCs), .FmaSs(FmaSs),
    .Sqrt(Sqrt), .FmaZero(FmaZero), .OpSel(OpSel), .OutValid(OutValid),
    .OutReady(OutReady), .OutTag(OutTag), .Ms(Ms)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every output transfer; also check hold stability.
  logic       hold_prev = 1'b0;
  logic [5:0] hold_val;
  always @(negedge clk) begin
    if (reset_n && !Flush) begin
      if (hold_prev && OutValid) check("hold_stable", 8'({OutTag, Ms}), 8'(hold_val));
      if (OutValid && OutReady) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 8'({OutTag, Ms}), 8'hFF);
        end else begin
          logic [5:0] e;
          e = sb_q.pop_front();
          check("out_tag", 8'(OutTag), 8'(e[5:2]));
          check("out_ms",  8'(Ms),     8'(e[1:0]));
        end
      end
      hold_prev = OutValid && !OutReady;
      hold_val  = {OutTag, Ms};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Called at posedge+1; leaves at posedge+1 of the accepting edge.
  task automatic send(input logic [3:0] tag, input logic [2:0] frm, input logic [3:0] op,
                      input logic [1:0] xs, input logic [1:0] ys, input logic [1:0] cvt,
                      input logic [1:0] fss, input logic [1:0] sq, input logic [1:0] fz,
                      input logic [1:0] exp_ms);
    logic ok;
    InValid = 1'b1; InTag = tag; Frm = frm; OpSel = op; Xs = xs; Ys = ys;
    CvtCs = cvt; FmaSs = fss; Sqrt = sq; FmaZero = fz;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = InReady;
      @(posedge clk);
    end
    if (ok) sb_q.push_back({tag, exp_ms});
    else check("accept_timeout", 8'(tag), 8'hEE);
    #1 InValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(posedge clk);
      c++;
    end
    #1 check(name, 8'(sb_q.size()), 8'd0);
  endtask

  initial begin
    reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; InTag = '0; Frm = '0;
    Xs = '0; Ys = '0; CvtCs = '0; FmaSs = '0; Sqrt = '0; FmaZero = '0; OpSel = '0;
    OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_outvalid", 8'(OutValid), 8'd0);
    check("rst_outtag",   8'(OutTag),   8'd0);
    check("rst_ms",       8'(Ms),       8'd0);
    check("rst_inready",  8'(InReady),  8'd1);
    @(posedge clk); #1;

    // Lane0 FMA sign, lane1 divide with equal signs; check two-cycle latency.
    send(4'd9, 3'b000, 4'b1001, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    @(negedge clk); check("latency_cycle1", 8'(OutValid), 8'd0);
    @(negedge clk); check("latency_cycle2", 8'(OutValid), 8'd1);
    drain("drain_t1");

    // FMA exact zero: RNE -> +0, RDN -> -0, mixed lanes under RUP.
    @(posedge clk); #1;
    send(4'd2, 3'b000, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
    send(4'd3, 3'b010, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11);
    send(4'd4, 3'b011, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10);
    // Sqrt ignores Ys; convert passes CvtCs; divide xors; OP_NONE forces 0.
    send(4'd5, 3'b000, 4'b1110, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10);
    send(4'd6, 3'b000, 4'b1010, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10);
    send(4'd7, 3'b010, 4'b0000, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
    drain("drain_directed");

    // Back-to-back tags 1..6 with a four-cycle downstream stall.
    @(posedge clk); #1;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          send(4'(t), 3'b000, 4'b1111, 2'b00, 2'b00, 2'(t), 2'b00, 2'b00, 2'b00, 2'(t));
      end
      begin
        repeat (2) @(posedge clk);
        #1 OutReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_inready", 8'(InReady), 8'd0);
        check("stall_outvalid", 8'(OutValid), 8'd1);
        @(posedge clk);
        #1 OutReady = 1'b1;
      end
    join
    drain("drain_stall");

    // Flush with two entries held; the tag offered during Flush must vanish.
    @(posedge clk); #1 OutReady = 1'b0;
    send(4'd10, 3'b000, 4'b0011, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    send(4'd11, 3'b000, 4'b0011, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    Flush = 1'b1; InValid = 1'b1; InTag = 4'd12;
    @(negedge clk);
    check("flush_inready", 8'(InReady), 8'd0);
    @(posedge clk);
    #1 Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("flush_outvalid", 8'(OutValid), 8'd0);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream clears outputs before the next edge.
    send(4'd13, 3'b000, 4'b1111, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    send(4'd14, 3'b000, 4'b1111, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    #2;
    check("pre_reset_outvalid", 8'(OutValid), 8'd1);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("areset_outvalid", 8'(OutValid), 8'd0);
    check("areset_ms",       8'(Ms),       8'd0);
    check("areset_outtag",   8'(OutTag),   8'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_inready", 8'(InReady), 8'd1);
    check("post_reset_outvalid", 8'(OutValid), 8'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
